// File: rtl/maxpool_stream.sv
// Streaming 1-D max-pooling: non-overlapping windows of P signed samples per L-sample frame,
// one registered maximum per window with a frame-last flag, valid/ready on both sides.
module maxpool_stream #(
  parameter int T = 8,
  parameter int L = 97,
  parameter int P = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         s_valid_y,
  output logic         s_ready_y,
  input  logic [T-1:0] s_data_in_y,
  output logic         m_valid_z,
  input  logic         m_ready_z,
  output logic [T-1:0] m_data_out_z,
  output logic         m_last_z
);

  localparam int FW = (L > 1) ? $clog2(L) : 1;
  localparam int WW = (P > 1) ? $clog2(P) : 1;
  localparam logic [FW-1:0] FRAME_LAST = FW'(L - 1);
  localparam logic [WW-1:0] WIN_LAST   = WW'(P - 1);

  logic [FW-1:0]       frame_cnt_reg, frame_cnt_next;
  logic [WW-1:0]       win_cnt_reg, win_cnt_next;
  logic signed [T-1:0] run_max_reg, run_max_next;
  logic                m_valid_reg, m_valid_next;
  logic [T-1:0]        m_data_reg, m_data_next;
  logic                m_last_reg, m_last_next;

  logic signed [T-1:0] sample;
  logic                accept;
  logic                frame_end;
  logic                win_close;

  assign sample    = $signed(s_data_in_y);
  // Input only stalls while a result is held and not being drained this cycle.
  assign s_ready_y = ~m_valid_reg | m_ready_z;
  assign accept    = s_valid_y & s_ready_y;
  assign frame_end = (frame_cnt_reg == FRAME_LAST);
  assign win_close = accept & ((win_cnt_reg == WIN_LAST) | frame_end);

  always_comb begin
    frame_cnt_next = frame_cnt_reg;
    win_cnt_next   = win_cnt_reg;
    run_max_next   = run_max_reg;
    m_valid_next   = m_valid_reg;
    m_data_next    = m_data_reg;
    m_last_next    = m_last_reg;

    if (accept) begin
      // First sample of a window loads directly so nothing leaks across windows or frames.
      if ((win_cnt_reg == '0) || (sample > run_max_reg)) begin
        run_max_next = sample;
      end
      frame_cnt_next = frame_end ? '0 : frame_cnt_reg + 1'b1;
      win_cnt_next   = win_close ? '0 : win_cnt_reg + 1'b1;
    end

    if (win_close) begin
      m_valid_next = 1'b1;
      m_data_next  = $unsigned(run_max_next);
      m_last_next  = frame_end;
    end else if (m_ready_z) begin
      m_valid_next = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      frame_cnt_reg <= '0;
      win_cnt_reg   <= '0;
      run_max_reg   <= '0;
      m_valid_reg   <= 1'b0;
      m_data_reg    <= '0;
      m_last_reg    <= 1'b0;
    end else begin
      frame_cnt_reg <= frame_cnt_next;
      win_cnt_reg   <= win_cnt_next;
      run_max_reg   <= run_max_next;
      m_valid_reg   <= m_valid_next;
      m_data_reg    <= m_data_next;
      m_last_reg    <= m_last_next;
    end
  end

  assign m_valid_z    = m_valid_reg;
  assign m_data_out_z = m_data_reg;
  assign m_last_z     = m_last_reg;

endmodule

// File: tb/tb_maxpool_stream.sv
// Bench for maxpool_stream: random streams checked against a per-frame window-max model,
// plus P=1 and P=97 instances driven with a single full frame.
module tb_maxpool_stream;

  localparam int T = 8;
  localparam int L = 97;
  localparam int P = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic         s_valid_y, s_ready_y;
  logic [T-1:0] s_data_in_y;
  logic         m_valid_z, m_ready_z, m_last_z;
  logic [T-1:0] m_data_out_z;

  logic         s_valid_x;
  logic [T-1:0] s_data_x;
  logic         s_ready_b, m_valid_b, m_last_b;
  logic [T-1:0] m_data_b;
  logic         s_ready_c, m_valid_c, m_last_c;
  logic [T-1:0] m_data_c;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int out_idx = 0;
  int rdy_mode;
  bit lat_chk;
  int fr [L];
  int exp_d [$];
  int exp_l [$];
  int close_q [$];
  int got_bd [$], got_bl [$], got_cd [$], got_cl [$];

  maxpool_stream #(.T(T), .L(L), .P(P)) dut (
    .clk(clk), .reset(reset),
    .s_valid_y(s_valid_y), .s_ready_y(s_ready_y), .s_data_in_y(s_data_in_y),
    .m_valid_z(m_valid_z), .m_ready_z(m_ready_z), .m_data_out_z(m_data_out_z),
    .m_last_z(m_last_z)
  );

  maxpool_stream #(.T(T), .L(L), .P(1)) dut_p1 (
    .clk(clk), .reset(reset),
    .s_valid_y(s_valid_x), .s_ready_y(s_ready_b), .s_data_in_y(s_data_x),
    .m_valid_z(m_valid_b), .m_ready_z(1'b1), .m_data_out_z(m_data_b),
    .m_last_z(m_last_b)
  );

  maxpool_stream #(.T(T), .L(L), .P(L)) dut_pl (
    .clk(clk), .reset(reset),
    .s_valid_y(s_valid_x), .s_ready_y(s_ready_c), .s_data_in_y(s_data_x),
    .m_valid_z(m_valid_c), .m_ready_z(1'b1), .m_data_out_z(m_data_c),
    .m_last_z(m_last_c)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: max of window w when a frame is cut into windows of p samples.
  function automatic int win_max(input int p, input int w);
    int lo = w * p;
    int hi = lo + p - 1;
    int m;
    if (hi > L - 1) hi = L - 1;
    m = fr[lo];
    for (int i = lo + 1; i <= hi; i++) if (fr[i] > m) m = fr[i];
    return m;
  endfunction

  // Downstream ready generator: 0 = always ready, 1 = random, 2 = stalled.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       m_ready_z = 1'b1;
        1:       m_ready_z = ($urandom_range(0, 2) != 0);
        default: m_ready_z = 1'b0;
      endcase
    end
  end

  // Output monitor for the main instance.
  always @(negedge clk) begin
    if (!reset && m_valid_z && m_ready_z) begin
      $display("out %0d data=%0d last=%0d cyc=%0d", out_idx, $signed(m_data_out_z), m_last_z, cyc);
      out_idx++;
      if (exp_d.size() == 0) begin
        check("extra_out", 1, 0);
      end else begin
        check("out_data", int'($signed(m_data_out_z)), exp_d.pop_front());
        check("out_last", int'(m_last_z), exp_l.pop_front());
        if (lat_chk) begin
          if (close_q.size() == 0) check("latency_no_close", cyc, -1);
          else check("latency", cyc, close_q.pop_front());
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!reset && m_valid_b) begin
      got_bd.push_back(int'($signed(m_data_b)));
      got_bl.push_back(int'(m_last_b));
    end
    if (!reset && m_valid_c) begin
      got_cd.push_back(int'($signed(m_data_c)));
      got_cl.push_back(int'(m_last_c));
    end
  end

  // Called at posedge+1; returns at posedge+1 after the sample has been accepted.
  task automatic send(input int v, input bit is_close);
    int n = 0;
    s_valid_y   = 1'b1;
    s_data_in_y = v[7:0];
    @(negedge clk);
    while (!s_ready_y && n < 2000) begin
      n++;
      @(negedge clk);
    end
    if (!s_ready_y) check("send_timeout", 0, 1);
    else if (lat_chk && is_close) close_q.push_back(cyc + 1);
    @(posedge clk);
    #1;
    s_valid_y = 1'b0;
  endtask

  task automatic send_frame(input bit gaps);
    int nw = (L + P - 1) / P;
    logic [31:0] r;
    for (int w = 0; w < nw; w++) begin
      exp_d.push_back(win_max(P, w));
      exp_l.push_back(int'(w == nw - 1));
    end
    for (int i = 0; i < L; i++) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        r = $urandom;
        s_valid_y   = 1'b0;
        s_data_in_y = r[7:0];
        repeat ($urandom_range(1, 2)) @(posedge clk);
        #1;
      end
      send(fr[i], (i % P == P - 1) || (i == L - 1));
    end
  endtask

  task automatic wait_drain(input string tag);
    int n = 0;
    while (exp_d.size() != 0 && n < 500) begin
      @(posedge clk);
      n++;
    end
    #1;
    check(tag, exp_d.size(), 0);
    exp_d.delete();
    exp_l.delete();
  endtask

  task automatic rand_frame();
    for (int i = 0; i < L; i++) fr[i] = int'($urandom_range(0, 255)) - 128;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int bad_v, bad_d, bad_r, n, nr;
    reset = 1'b1;
    s_valid_y = 1'b0;
    s_data_in_y = '0;
    s_valid_x = 1'b0;
    s_data_x = '0;
    m_ready_z = 1'b1;
    rdy_mode = 0;
    lat_chk = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("rst_m_valid", int'(m_valid_z), 0);
    check("rst_m_data", int'(m_data_out_z), 0);
    check("rst_m_last", int'(m_last_z), 0);
    check("rst_s_ready", int'(s_ready_y), 1);
    @(posedge clk);
    #1;

    // Ramp frame, continuous, with one-cycle latency check.
    for (int i = 0; i < L; i++) fr[i] = i % 128;
    lat_chk = 1'b1;
    send_frame(1'b0);
    wait_drain("ramp_drain");
    lat_chk = 1'b0;
    close_q.delete();

    // Signed corner windows.
    rand_frame();
    fr[0] = -5;   fr[1] = -128; fr[2]  = -1;   fr[3]  = -7;
    fr[4] = 127;  fr[5] = -128; fr[6]  = 0;    fr[7]  = 5;
    fr[8] = -128; fr[9] = -128; fr[10] = -128; fr[11] = -128;
    send_frame(1'b0);
    wait_drain("signed_drain");

    // Backpressure held for 10 cycles on the first window.
    for (int i = 0; i < L; i++) fr[i] = i % 128;
    rdy_mode = 2;
    m_ready_z = 1'b0;
    fork
      send_frame(1'b0);
      begin
        n = 0;
        @(negedge clk);
        while (!m_valid_z && n < 100) begin
          n++;
          @(negedge clk);
        end
        check("bp_valid_seen", int'(m_valid_z), 1);
        bad_v = 0; bad_d = 0; bad_r = 0;
        repeat (10) begin
          if (!m_valid_z) bad_v++;
          if (int'($signed(m_data_out_z)) != 3) bad_d++;
          if (s_ready_y) bad_r++;
          @(negedge clk);
        end
        check("bp_valid_drops", bad_v, 0);
        check("bp_data_changes", bad_d, 0);
        check("bp_ready_high", bad_r, 0);
        @(posedge clk);
        #1;
        rdy_mode = 0;
        m_ready_z = 1'b1;
      end
    join
    wait_drain("bp_drain");

    // Two back-to-back frames with random gaps on both sides.
    rdy_mode = 1;
    rand_frame();
    fr[L-1] = 127;
    send_frame(1'b1);
    rand_frame();
    for (int i = 0; i < P; i++) fr[i] = int'($urandom_range(0, 127)) - 128;
    send_frame(1'b1);
    wait_drain("b2b_drain");

    // Reset mid-frame while a result is held.
    rdy_mode = 2;
    m_ready_z = 1'b0;
    rand_frame();
    for (int i = 0; i < 4; i++) send(fr[i], 1'b0);
    s_valid_y = 1'b1;
    s_data_in_y = 8'h55;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    check("pre_rst_held", int'(m_valid_z), 1);
    check("pre_rst_stall", int'(s_ready_y), 0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    s_valid_y = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    exp_d.delete();
    exp_l.delete();
    @(negedge clk);
    check("post_rst_valid", int'(m_valid_z), 0);
    check("post_rst_ready", int'(s_ready_y), 1);
    @(posedge clk);
    #1;
    rdy_mode = 1;
    rand_frame();
    send_frame(1'b1);
    wait_drain("post_rst_drain");
    rdy_mode = 0;

    // Parameter sweep instances: one continuous frame each.
    rand_frame();
    nr = 0;
    for (int i = 0; i < L; i++) begin
      s_valid_x = 1'b1;
      s_data_x  = fr[i][7:0];
      @(negedge clk);
      if (!(s_ready_b && s_ready_c)) nr++;
      @(posedge clk);
      #1;
    end
    s_valid_x = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("sweep_not_ready", nr, 0);
    check("p1_count", got_bd.size(), L);
    for (int w = 0; w < L && w < got_bd.size(); w++) begin
      check("p1_data", got_bd[w], win_max(1, w));
      check("p1_last", got_bl[w], int'(w == L - 1));
    end
    check("pl_count", got_cd.size(), 1);
    if (got_cd.size() > 0) begin
      check("pl_data", got_cd[0], win_max(L, 0));
      check("pl_last", got_cl[0], 1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
